uart_tx_fsm: RTL
================

Name: uart_tx_fsm

Overview:
Frame sequencer for the UART transmitter. It accepts a parallel word handshake and steps the TX line through a frame: start bit, DATA_WIDTH data bits (LSB first), an optional parity bit, then a stop bit. It drives the TX output mux select, and the load/shift controls of the serializer. It latches the parity configuration per frame so the parity calculator and mux stay consistent. One bit is transmitted per CLK cycle; CLK is the baud-rate clock.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (2..16).
CNT_WIDTH, $clog2(DATA_WIDTH), width of the internal data-bit counter.

Ports:
CLK  input  1  baud-rate clock, rising edge.
RST  input  1  asynchronous, active-low reset.
Data_Valid  input  1  request to send a word; sampled only when the block can accept.
PAR_EN  input  1  parity enable for the frame; latched on accept.
PAR_TYP  input  1  parity type for the frame, 0 = even, 1 = odd; latched on accept.
Data_Accept  output  1  one-cycle pulse in the cycle Data_Valid is accepted (combinational from state and Data_Valid).
Ser_Load  output  1  equals Data_Accept; the serializer captures P_DATA on that edge.
Ser_Enable  output  1  serializer shifts one bit per cycle while high.
MUX_Selection  output  2  00 = logic one (idle/stop), 01 = logic zero (start), 10 = serial data, 11 = parity.
Par_En_Q  output  1  latched PAR_EN for the current frame.
Par_Typ_Q  output  1  latched PAR_TYP for the current frame.
Busy  output  1  high from the start bit through the stop bit.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. The state is held in a register and the outputs are Moore-decoded from it, except Data_Accept and Ser_Load.
- Reset (RST low, async):
  - State is IDLE and the bit counter is 0.
  - Par_En_Q and Par_Typ_Q are 0.
  - Busy is 0, MUX_Selection is 00, Ser_Enable is 0, Data_Accept and Ser_Load are 0.
  - Reset mid-frame aborts the frame immediately and the line returns to 1 without completing the stop bit.
- Accept condition: (state == IDLE or state == STOP) and Data_Valid == 1. On the accepting edge, PAR_EN and PAR_TYP are latched and the next state is START.
- Per-state outputs and transitions:
  - IDLE: MUX 00, Busy 0, Ser_Enable 0. Goes to START on accept, otherwise stays in IDLE.
  - START: MUX 01, Busy 1. Lasts exactly 1 cycle, then goes to DATA and clears the counter to 0.
  - DATA: MUX 10, Busy 1, Ser_Enable 1. The counter increments every cycle. When counter == DATA_WIDTH-1, the next state is PARITY if Par_En_Q is 1, otherwise STOP. DATA always lasts exactly DATA_WIDTH cycles.
  - PARITY: MUX 11, Busy 1, Ser_Enable 0. Lasts 1 cycle, then goes to STOP.
  - STOP: MUX 00, Busy 1. Lasts 1 cycle. Goes to START on accept (back-to-back frames with no idle gap), otherwise to IDLE.
- Latency: from the accepting edge, the start bit appears on the line for that clock period. Frame length is DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
- Data_Valid while in START, DATA or PARITY is ignored: no accept pulse and no effect. The requester must hold Data_Valid until it sees Data_Accept.
- PAR_EN and PAR_TYP changing mid-frame have no effect on the current frame.
- The counter never exceeds DATA_WIDTH-1 and does not wrap inside DATA. Outside DATA it holds 0.
- Illegal or unused state encodings decode to IDLE outputs and return to IDLE on the next edge.

Decomposition:
- Shared package uart_tx_pkg holds two things:
  - The MUX_Selection encoding constants LOGIC_ONE=2'b00, LOGIC_ZERO=2'b01, DATA_BITS=2'b10 and PARITY_BIT=2'b11, shared with the TX output mux.
  - The state encoding constants IDLE, START, DATA, PARITY and STOP (3 bits).
- No sub-module. The bit counter is small enough to live inline.

Test Plan:
- Reset check: assert RST low mid-DATA -> next sample shows Busy=0, MUX=00, Ser_Enable=0. Release reset with Data_Valid=0 -> block stays in IDLE.
- Single frame, PAR_EN=0: pulse Data_Valid -> Data_Accept=1 for 1 cycle. MUX sequence must be 01, then 10 for 8 cycles, then 00. Busy is high for 10 cycles and Ser_Enable is high for exactly 8 cycles.
- Single frame, PAR_EN=1 and PAR_TYP=1: MUX sequence must be 01, 10 for 8 cycles, 11, then 00. Busy is high for 11 cycles and Par_Typ_Q=1 throughout.
- Back-to-back frames: hold Data_Valid=1 continuously -> Data_Accept asserts during each STOP cycle. The next START follows STOP with no idle cycle, so frames repeat every 10 cycles.
- Config and request changes mid-frame: toggle PAR_EN 0->1 and pulse Data_Valid during DATA -> no Data_Accept, no parity cycle, and the frame is unchanged.
- DATA_WIDTH=5 instance with PAR_EN=1 -> exactly 5 DATA cycles, then PARITY, then STOP.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmitter: TX output mux select values
// and the frame sequencer state encoding.
package uart_tx_pkg;

   localparam logic [1:0] LOGIC_ONE  = 2'b00;
   localparam logic [1:0] LOGIC_ZERO = 2'b01;
   localparam logic [1:0] DATA_BITS  = 2'b10;
   localparam logic [1:0] PARITY_BIT = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits LSB first, optional
// parity, stop. One bit per CLK cycle; parity config is latched per frame.
module uart_tx_fsm
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   output logic       Data_Accept,
   output logic       Ser_Load,
   output logic       Ser_Enable,
   output logic [1:0] MUX_Selection,
   output logic       Par_En_Q,
   output logic       Par_Typ_Q,
   output logic       Busy
);

   // Handshake: a word is taken when Data_Valid is high in IDLE or STOP;
   // Data_Accept pulses in that same cycle and the requester then drops or
   // re-presents Data_Valid. Requests in START/DATA/PARITY are ignored.

   state_t                 r_state;
   state_t                 w_next_state;
   logic   [CNT_WIDTH-1:0] r_cnt;
   logic   [CNT_WIDTH-1:0] w_cnt_next;
   logic                   r_par_en;
   logic                   r_par_typ;
   logic                   w_accept;
   logic                   w_cnt_last;

   assign w_cnt_last = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
         end
      end
   end

   always_comb begin
      w_next_state  = IDLE;
      w_cnt_next    = '0;
      w_accept      = 1'b0;
      Ser_Enable    = 1'b0;
      MUX_Selection = LOGIC_ONE;
      Busy          = 1'b0;
      case (r_state)
         IDLE: begin
            w_accept     = Data_Valid;
            w_next_state = Data_Valid ? START : IDLE;
         end
         START: begin
            MUX_Selection = LOGIC_ZERO;
            Busy          = 1'b1;
            w_next_state  = DATA;
         end
         DATA: begin
            MUX_Selection = DATA_BITS;
            Busy          = 1'b1;
            Ser_Enable    = 1'b1;
            // Counter saturates into 0 on the last bit, so it reads 0 outside DATA.
            if (w_cnt_last) begin
               w_next_state = r_par_en ? PARITY : STOP;
            end else begin
               w_next_state = DATA;
               w_cnt_next   = r_cnt + 1'b1;
            end
         end
         PARITY: begin
            MUX_Selection = PARITY_BIT;
            Busy          = 1'b1;
            w_next_state  = STOP;
         end
         STOP: begin
            Busy         = 1'b1;
            w_accept     = Data_Valid;
            w_next_state = Data_Valid ? START : IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign Data_Accept = w_accept;
   assign Ser_Load    = w_accept;
   assign Par_En_Q    = r_par_en;
   assign Par_Typ_Q   = r_par_typ;

endmodule
